irq_pending_latch: RTL and testbench

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

---
 rtl/irq_pending_latch.sv | 83 ++++++++
 tb/tb_irq_pending_latch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Interrupt request front end. Synchronizes eight asynchronous level requests,
// latches their rising edges as pending bits and flags events lost while pending.

module irq_pending_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack_hit,
  input  logic clr_overrun,
  output logic pend,
  output logic overrun
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  assign rise = sync[SYNC_STAGES-1] & ~prev;

  // A new edge beats a same-cycle ack, and an overrun being raised beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      prev    <= 1'b0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], req};
      prev    <= sync[SYNC_STAGES-1];
      pend    <= rise | (pend & ~ack_hit);
      overrun <= (rise & pend & ~ack_hit) | (overrun & ~clr_overrun);
    end
  end

endmodule

module irq_pending_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_code,
  input  logic       clr_overrun,
  output logic [7:0] pending,
  output logic       any_pending,
  output logic [7:0] overrun
);

  localparam int NUM_LANES = 8;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("irq_pending_latch: SYNC_STAGES must be in 2..4");
  end

  logic [NUM_LANES-1:0] ack_hit;
  logic [NUM_LANES-1:0] pend;

  assign ack_hit = ack ? (NUM_LANES'(1) << ack_code) : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    irq_pending_lane #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .req        (req_in[i]),
      .ack_hit    (ack_hit[i]),
      .clr_overrun(clr_overrun),
      .pend       (pend[i]),
      .overrun    (overrun[i])
    );
  end

  // Masking only gates the view; the latched state is untouched.
  assign pending     = pend & mask;
  assign any_pending = |pending;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios plus randomized
// traffic compared against a delayed-sample behavioural model.

module tb_irq_pending_latch;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = '0;
  logic [7:0] mask = 8'hFF;
  logic       ack = 1'b0;
  logic [2:0] ack_code = '0;
  logic       clr_overrun = 1'b0;
  logic [7:0] pending;
  logic       any_pending;
  logic [7:0] overrun;

  int nchk = 0;
  int nerr = 0;

  // model: h[i] = req_in sampled i+1 edges ago (zeroed by reset)
  logic [7:0] h [0:5];
  logic [7:0] mpend;
  logic [7:0] movr;

  irq_pending_latch #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .mask       (mask),
    .ack        (ack),
    .ack_code   (ack_code),
    .clr_overrun(clr_overrun),
    .pending    (pending),
    .any_pending(any_pending),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One edge: the model sees the same pre-edge inputs as the DUT.
  task automatic model_edge();
    logic [7:0] rise;
    if (rst) begin
      for (int i = 0; i < 6; i++) h[i] = '0;
      mpend = '0;
      movr  = '0;
    end else begin
      rise = h[S-1] & ~h[S];
      for (int k = 0; k < 8; k++) begin
        bit acked;
        acked = ack && (ack_code == 3'(k));
        if (clr_overrun) movr[k] = 1'b0;
        if (rise[k] && mpend[k] && !acked) movr[k] = 1'b1;
        if (acked) mpend[k] = 1'b0;
        if (rise[k]) mpend[k] = 1'b1;
      end
      for (int i = 5; i > 0; i--) h[i] = h[i-1];
      h[0] = req_in;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pending"}, pending, mpend & mask);
    chk({tag, ".any"}, {7'd0, any_pending}, {7'd0, |(mpend & mask)});
    chk({tag, ".overrun"}, overrun, movr);
  endtask

  task automatic step(input logic [7:0] r, input logic a, input logic [2:0] c,
                      input logic clr, input logic rs);
    req_in = r; ack = a; ack_code = c; clr_overrun = clr; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_model("model");
  endtask

  initial begin
    for (int i = 0; i < 6; i++) h[i] = '0;
    mpend = '0;
    movr  = '0;

    // reset
    step(8'h00, 0, 0, 0, 1);
    step(8'hFF, 1, 0, 1, 1);
    chk("reset.pending", pending, 8'h00);
    chk("reset.overrun", overrun, 8'h00);

    // edge latency on line 5
    step(8'h20, 0, 0, 0, 0);
    chk("lat.n", pending, 8'h00);
    step(8'h00, 0, 0, 0, 0);
    chk("lat.n1", pending, 8'h00);
    step(8'h00, 0, 0, 0, 0);
    chk("lat.n2", pending, 8'h20);
    chk("lat.any", {7'd0, any_pending}, 8'h01);

    // ack line 7 then ack an idle line
    step(8'h80, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    chk("ack.pre", pending, 8'hA0);
    step(8'h00, 1, 3'd7, 0, 0);
    chk("ack.7", pending, 8'h20);
    step(8'h00, 1, 3'd0, 0, 0);
    chk("ack.idle", pending, 8'h20);

    // overrun on line 2, then collision with ack, then clear
    step(8'h04, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h04, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    chk("ovr.set", overrun, 8'h04);
    chk("ovr.pend", pending, 8'h24);
    step(8'h04, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 1, 3'd2, 0, 0);
    chk("coll.pend", pending, 8'h24);
    chk("coll.ovr", overrun, 8'h04);
    step(8'h00, 0, 0, 1, 0);
    chk("clr.ovr", overrun, 8'h00);

    // mask hides and re-exposes without touching pend
    step(8'h00, 0, 0, 0, 1);
    step(8'h81, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    mask = 8'h01; #1;
    chk("mask.hide", pending, 8'h01);
    mask = 8'hFF; #1;
    chk("mask.show", pending, 8'h81);

    // reset with a line held high and overrun live
    step(8'h01, 0, 0, 0, 0);
    step(8'h10, 0, 0, 0, 0);
    step(8'h10, 0, 0, 0, 0);
    chk("rst.pre.ovr", overrun, 8'h01);
    step(8'h10, 1, 3'd0, 1, 1);
    chk("rst.pending", pending, 8'h00);
    chk("rst.overrun", overrun, 8'h00);
    chk("rst.any", {7'd0, any_pending}, 8'h00);
    step(8'h10, 0, 0, 0, 0);
    chk("rst.e1", pending, 8'h00);
    step(8'h10, 0, 0, 0, 0);
    chk("rst.e2", pending, 8'h00);
    step(8'h10, 0, 0, 0, 0);
    chk("rst.e3", pending, 8'h10);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      r = req_in;
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      step(r, ($urandom_range(0, 2) == 0), 3'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
